dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Parametrised successor to the single-port data memory wrapper. Inferred synchronous RAM with byte-lane writes, sub-word loads with sign/zero extension, a valid/ready request channel and a fixed-latency in-order response channel.
- Adds alignment/range checking and a post-reset initialisation sequencer.
- Sits between the CPU load/store stage and on-chip data storage; replaces the direct IP-core instance.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of 2, minimum 4.
- READ_LAT, 1, response latency in cycles after acceptance; legal values 1 or 2 (2 adds an output register).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; transfer when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or reserved-size request.
- init_busy  out  1  initialisation sequencer active.

Behaviour:
- Reset values (async on rst_n low): req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_busy=1 when DMEM_INIT_CLEAR_EN is defined, else 0. RAM contents are not reset by rst_n.
- FSM states:
  - INIT: zero-fill counter walks word 0..DEPTH_WORDS-1, one write per cycle. Leaves to RUN after the last word. Takes exactly DEPTH_WORDS cycles after rst_n deasserts.
  - RUN: req_ready=1 every cycle; no backpressure on responses.
- Throughput and latency:
  - One request accepted per cycle, no bubbles.
  - Response for a request accepted in cycle N appears in cycle N+READ_LAT, strictly in order.
- Address decode:
  - off = req_addr - BASE_ADDR.
  - Out of range when req_addr < BASE_ADDR or off >= DEPTH_WORDS*4.
  - Word index = off[log2(DEPTH_WORDS)+1:2]; lane = off[1:0].
- Error checks, evaluated at acceptance:
  - size 11 is an error.
  - half with lane[0]=1 is an error.
  - word with lane!=0 is an error.
  - any out-of-range address is an error.
  - Error requests: no RAM write; resp_valid with resp_err=1 and resp_rdata=0 at the normal latency.
- Stores, little-endian:
  - byte writes lane `lane`.
  - half writes lanes lane and lane+1.
  - word writes all four lanes.
  - Unwritten lanes are unchanged.
  - Store response: resp_err=0, resp_rdata=0.
- Loads:
  - Read the word, then select the byte or half at `lane` and shift it to bit 0.
  - Extend per req_unsigned; word loads pass through unchanged.
  - Size, lane and unsigned are carried down the response pipeline alongside the request.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data. Requires a write-first RAM or an explicit bypass.
- Reset mid-operation: in-flight responses are discarded (no resp_valid after reset). INIT restarts from word 0 when DMEM_INIT_CLEAR_EN is defined.
- req_valid while req_ready=0 (reset or INIT) is ignored; the requester must hold it.

Optional Feature:
- DMEM_INIT_CLEAR_EN defined:
  - INIT state present; RAM zero-filled after every reset.
  - init_busy=1 and req_ready=0 during the fill.
- DMEM_INIT_CLEAR_EN undefined:
  - INIT state absent; controller enters RUN on the first clock after rst_n deasserts.
  - init_busy tied 0; contents undefined until written.

Test Plan:
- Word store then load: store 0xDEADBEEF @BASE+0x10, load word @0x10 the next cycle → resp_rdata=0xDEADBEEF, resp_err=0, READ_LAT cycles after each acceptance.
- Sub-word loads: after the word above, load byte @0x13 signed → 0xFFFFFFDE; unsigned → 0x000000DE; half @0x10 signed → 0xFFFFBEEF.
- Byte-lane store: store byte 0x5A @0x11, then load word @0x10 → 0xDEAD5AEF.
- Errors: half @0x11, word @0x12, size 11, and word @BASE+DEPTH_WORDS*4 → each gives resp_err=1, rdata=0. A following load @0x10 still returns 0xDEAD5AEF, proving no write occurred.
- Back-to-back throughput with READ_LAT=2: 8 consecutive loads of distinct words → 8 consecutive resp_valid cycles, in order, first response 2 cycles after the first accept.
- Reset/init (macro defined, DEPTH_WORDS=16): pulse rst_n low mid-stream → no stale resp_valid. init_busy stays high for exactly 16 cycles, and the load @0x10 then returns 0.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-port data memory controller.
// Inferred synchronous RAM with byte-lane stores, sub-word loads with
// sign/zero extension, a valid/ready request channel and a fixed-latency
// (READ_LAT = 1 or 2) in-order response channel. Misaligned, out-of-range
// and reserved-size requests complete with resp_err and never write.
// Optional build macro DMEM_INIT_CLEAR_EN adds a post-reset sequencer that
// zero-fills every word before the first request is accepted.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; the requester holds all req_* fields stable until
// then. Each transfer produces exactly one single-cycle resp_valid pulse
// READ_LAT cycles later, in acceptance order, with no response backpressure.
module dmem_ctrl #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned READ_LAT    = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        init_busy
);

   localparam int unsigned AW          = $clog2(DEPTH_WORDS);
   localparam logic [32:0] RANGE_BYTES = 33'(DEPTH_WORDS) << 2;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

`ifdef DMEM_INIT_CLEAR_EN
   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;
   localparam state_e RESET_STATE = ST_INIT;
   logic [AW-1:0] init_cnt_q, init_cnt_d;
`else
   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;
   localparam state_e RESET_STATE = ST_IDLE;
`endif

   state_e state_q, state_d;

   // request decode
   logic [31:0]   off;
   logic [AW-1:0] word_idx;
   logic [1:0]    lane;
   logic          out_of_range;
   logic          size_err;
   logic          align_err;
   logic          req_err;
   logic          accept;

   // RAM ports
   logic [31:0]   mem_q [DEPTH_WORDS];
   logic          ram_we;
   logic [AW-1:0] ram_widx;
   logic [3:0]    ram_be;
   logic [31:0]   ram_wdata;
   logic [31:0]   rdata_raw_q;

   // first response stage: metadata travelling with the RAM read
   logic          s1_valid_q;
   logic          s1_err_q;
   logic          s1_load_q;
   logic [1:0]    s1_size_q;
   logic [1:0]    s1_lane_q;
   logic          s1_uns_q;
   logic [7:0]    sel_byte;
   logic [15:0]   sel_half;
   logic [31:0]   load_data;
   logic [31:0]   s1_rdata;

   assign off          = req_addr - BASE_ADDR;
   assign out_of_range = (req_addr < BASE_ADDR) || ({1'b0, off} >= RANGE_BYTES);
   assign word_idx     = off[AW+1:2];
   assign lane         = off[1:0];
   assign accept       = req_valid & req_ready;

   // classify the request; any error suppresses the write and the load data
   always_comb begin
      size_err  = (req_size == 2'b11);
      align_err = ((req_size == SZ_HALF) && lane[0]) ||
                  ((req_size == SZ_WORD) && (lane != 2'b00));
      req_err   = size_err | align_err | out_of_range;
   end

   // control state register (and fill counter when the sequencer is built)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RESET_STATE;
`ifdef DMEM_INIT_CLEAR_EN
         init_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
`ifdef DMEM_INIT_CLEAR_EN
         init_cnt_q <= init_cnt_d;
`endif
      end
   end

   // next state and handshake outputs
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      init_busy = 1'b0;
`ifdef DMEM_INIT_CLEAR_EN
      init_cnt_d = init_cnt_q;
`endif
      case (state_q)
`ifdef DMEM_INIT_CLEAR_EN
         ST_INIT: begin
            init_busy  = 1'b1;
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == {AW{1'b1}}) begin
               state_d = ST_RUN;
            end
         end
`else
         ST_IDLE: begin
            state_d = ST_RUN;
         end
`endif
         ST_RUN: begin
            req_ready = 1'b1;
         end
         default: begin
            state_d = RESET_STATE;
         end
      endcase
   end

   // steer store data onto byte lanes; the fill sequencer owns the port during INIT
   always_comb begin
      ram_we    = 1'b0;
      ram_widx  = word_idx;
      ram_be    = 4'b0000;
      ram_wdata = 32'h0;
      if (accept && req_we && !req_err) begin
         ram_we = 1'b1;
         case (req_size)
            SZ_BYTE: begin
               ram_be    = 4'b0001 << lane;
               ram_wdata = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
               ram_be    = 4'b0011 << lane;
               ram_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
               ram_be    = 4'b1111;
               ram_wdata = req_wdata;
            end
         endcase
      end
`ifdef DMEM_INIT_CLEAR_EN
      if (state_q == ST_INIT) begin
         ram_we    = 1'b1;
         ram_widx  = init_cnt_q;
         ram_be    = 4'b1111;
         ram_wdata = 32'h0;
      end
`endif
   end

   // RAM array: byte-enabled write, registered read (contents survive rst_n)
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (ram_be[i]) begin
               mem_q[ram_widx][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
         end
      end
      if (accept && !req_we) begin
         rdata_raw_q <= mem_q[word_idx];
      end
   end

   // carry size/lane/extension alongside the read so the result can be shaped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_err_q   <= 1'b0;
         s1_load_q  <= 1'b0;
         s1_size_q  <= 2'b00;
         s1_lane_q  <= 2'b00;
         s1_uns_q   <= 1'b0;
      end else begin
         s1_valid_q <= accept;
         s1_err_q   <= req_err;
         s1_load_q  <= ~req_we;
         s1_size_q  <= req_size;
         s1_lane_q  <= lane;
         s1_uns_q   <= req_unsigned;
      end
   end

   // select the addressed byte/half, shift to bit 0 and extend
   always_comb begin
      sel_byte  = rdata_raw_q[{s1_lane_q, 3'b000} +: 8];
      sel_half  = s1_lane_q[1] ? rdata_raw_q[31:16] : rdata_raw_q[15:0];
      load_data = rdata_raw_q;
      case (s1_size_q)
         SZ_BYTE: load_data = {{24{~s1_uns_q & sel_byte[7]}}, sel_byte};
         SZ_HALF: load_data = {{16{~s1_uns_q & sel_half[15]}}, sel_half};
         default: load_data = rdata_raw_q;
      endcase
      s1_rdata = (s1_valid_q && s1_load_q && !s1_err_q) ? load_data : 32'h0;
   end

   generate
      if (READ_LAT == 2) begin : g_lat2
         logic        s2_valid_q;
         logic        s2_err_q;
         logic [31:0] s2_rdata_q;

         // extra output register for the two-cycle latency build
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_valid_q <= 1'b0;
               s2_err_q   <= 1'b0;
               s2_rdata_q <= 32'h0;
            end else begin
               s2_valid_q <= s1_valid_q;
               s2_err_q   <= s1_valid_q & s1_err_q;
               s2_rdata_q <= s1_rdata;
            end
         end

         assign resp_valid = s2_valid_q;
         assign resp_err   = s2_err_q;
         assign resp_rdata = s2_rdata_q;
      end else begin : g_lat1
         assign resp_valid = s1_valid_q;
         assign resp_err   = s1_valid_q & s1_err_q;
         assign resp_rdata = s1_rdata;
      end
   endgenerate

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench for dmem_ctrl. Two instances (READ_LAT 1 and
// 2, DEPTH_WORDS 16, BASE 0x1000) share one request stream; each has its own
// response scoreboard that checks data, error flag and exact response cycle.
module tb_dmem_ctrl;

   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef DMEM_INIT_CLEAR_EN
   localparam bit INIT_EN = 1'b1;
`else
   localparam bit INIT_EN = 1'b0;
`endif

   localparam logic [1:0] B = 2'b00;
   localparam logic [1:0] H = 2'b01;
   localparam logic [1:0] W = 2'b10;
   localparam logic [1:0] R = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;

   logic        rdy1, rvld1, rerr1, busy1;
   logic [31:0] rdata1;
   logic        rdy2, rvld2, rerr2, busy2;
   logic [31:0] rdata2;

   logic [31:0] drv_exp_rdata = 32'h0;
   logic        drv_exp_err = 1'b0;

   int          cyc = 0;
   int          n_pass = 0;
   int          n_total = 0;
   logic [64:0] exp_q1[$];
   logic [64:0] exp_q2[$];
   logic [64:0] e1, e2;

   dmem_ctrl #(.DEPTH_WORDS(DEPTH), .READ_LAT(1), .BASE_ADDR(BASE)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rvld1),
      .resp_rdata(rdata1), .resp_err(rerr1), .init_busy(busy1)
   );

   dmem_ctrl #(.DEPTH_WORDS(DEPTH), .READ_LAT(2), .BASE_ADDR(BASE)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy2),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rvld2),
      .resp_rdata(rdata2), .resp_err(rerr2), .init_busy(busy2)
   );

   // clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   // scoreboard for the READ_LAT=1 instance
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q1.delete();
         check("rst_resp_valid_1", 32'(rvld1), 32'h0);
         check("rst_resp_rdata_1", rdata1, 32'h0);
         check("rst_resp_err_1", 32'(rerr1), 32'h0);
      end else begin
         if (rvld1) begin
            check("resp_expected_1", 32'(exp_q1.size() != 0), 32'h1);
            if (exp_q1.size() != 0) begin
               e1 = exp_q1.pop_front();
               check("rdata_1", rdata1, e1[31:0]);
               check("err_1", 32'(rerr1), 32'(e1[32]));
               check("resp_cycle_1", 32'(cyc), e1[64:33]);
            end
         end else if (exp_q1.size() != 0 && 32'(cyc) >= exp_q1[0][64:33]) begin
            check("resp_valid_1", 32'(rvld1), 32'h1);
            void'(exp_q1.pop_front());
         end
         if (req_valid && rdy1) exp_q1.push_back({32'(cyc + 1), drv_exp_err, drv_exp_rdata});
      end
   end

   // scoreboard for the READ_LAT=2 instance
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q2.delete();
         check("rst_resp_valid_2", 32'(rvld2), 32'h0);
         check("rst_resp_rdata_2", rdata2, 32'h0);
         check("rst_resp_err_2", 32'(rerr2), 32'h0);
      end else begin
         if (rvld2) begin
            check("resp_expected_2", 32'(exp_q2.size() != 0), 32'h1);
            if (exp_q2.size() != 0) begin
               e2 = exp_q2.pop_front();
               check("rdata_2", rdata2, e2[31:0]);
               check("err_2", 32'(rerr2), 32'(e2[32]));
               check("resp_cycle_2", 32'(cyc), e2[64:33]);
            end
         end else if (exp_q2.size() != 0 && 32'(cyc) >= exp_q2[0][64:33]) begin
            check("resp_valid_2", 32'(rvld2), 32'h1);
            void'(exp_q2.pop_front());
         end
         if (req_valid && rdy2) exp_q2.push_back({32'(cyc + 2), drv_exp_err, drv_exp_rdata});
      end
   end

   // present one request and hold it until both instances take it
   task automatic send(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
      int n = 0;
      req_valid     = 1'b1;
      req_we        = we;
      req_size      = size;
      req_unsigned  = uns;
      req_addr      = addr;
      req_wdata     = wdata;
      drv_exp_rdata = exp_rdata;
      drv_exp_err   = exp_err;
      while (!(rdy1 && rdy2) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) check("req_ready_wait", 32'(rdy1 && rdy2), 32'h1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // called #1 after the edge that releases rst_n; times the fill phase
   task automatic measure_init(input string tag);
      int k = 0;
      int busy_cnt1 = 0;
      int busy_cnt2 = 0;
      while (k < 100) begin
         @(negedge clk);
         if (rdy1 && rdy2) break;
         k++;
         if (busy1) busy_cnt1++;
         if (busy2) busy_cnt2++;
      end
      check({tag, "_cycles_to_ready"}, 32'(k), INIT_EN ? 32'(DEPTH) : 32'd1);
      check({tag, "_busy_cycles_1"}, 32'(busy_cnt1), INIT_EN ? 32'(DEPTH) : 32'd0);
      check({tag, "_busy_cycles_2"}, 32'(busy_cnt2), INIT_EN ? 32'(DEPTH) : 32'd0);
      check({tag, "_busy_after_1"}, 32'(busy1), 32'h0);
      check({tag, "_busy_after_2"}, 32'(busy2), 32'h0);
      @(posedge clk);
      #1;
   endtask

   // directed sequence
   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready_1", 32'(rdy1), 32'h0);
      check("rst_req_ready_2", 32'(rdy2), 32'h0);
      check("rst_init_busy_1", 32'(busy1), 32'(INIT_EN));
      check("rst_init_busy_2", 32'(busy2), 32'(INIT_EN));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      measure_init("init0");

      // word store then back-to-back load, sub-word loads
      send(1'b1, W, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
      send(1'b0, W, 1'b0, BASE + 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
      send(1'b0, B, 1'b0, BASE + 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0);
      send(1'b0, B, 1'b1, BASE + 32'h13, 32'h0, 32'h0000_00DE, 1'b0);
      send(1'b0, H, 1'b0, BASE + 32'h10, 32'h0, 32'hFFFF_BEEF, 1'b0);
      send(1'b0, H, 1'b1, BASE + 32'h12, 32'h0, 32'h0000_DEAD, 1'b0);

      // byte-lane store: upper wdata bits must be ignored
      send(1'b1, B, 1'b0, BASE + 32'h11, 32'hFFFF_FF5A, 32'h0, 1'b0);
      send(1'b0, W, 1'b0, BASE + 32'h10, 32'h0, 32'hDEAD_5AEF, 1'b0);

      // words that out-of-range addresses would alias onto if decode wrapped
      send(1'b1, W, 1'b0, BASE + 32'h00, 32'h0102_0304, 32'h0, 1'b0);
      send(1'b1, W, 1'b0, BASE + 32'h3C, 32'h0F0F_0F0F, 32'h0, 1'b0);

      // error requests: no write, err=1, rdata=0
      send(1'b1, H, 1'b0, BASE + 32'h11, 32'h0000_1234, 32'h0, 1'b1);
      send(1'b1, W, 1'b0, BASE + 32'h12, 32'h1234_5678, 32'h0, 1'b1);
      send(1'b1, R, 1'b0, BASE + 32'h10, 32'hCAFE_F00D, 32'h0, 1'b1);
      send(1'b1, W, 1'b0, BASE + 32'h40, 32'h0BAD_C0DE, 32'h0, 1'b1);
      send(1'b1, W, 1'b0, BASE - 32'h4, 32'h0BAD_0BAD, 32'h0, 1'b1);
      send(1'b0, H, 1'b0, BASE + 32'h13, 32'h0, 32'h0, 1'b1);
      send(1'b0, W, 1'b0, BASE + 32'h40, 32'h0, 32'h0, 1'b1);
      send(1'b0, W, 1'b0, BASE + 32'h10, 32'h0, 32'hDEAD_5AEF, 1'b0);
      send(1'b0, W, 1'b0, BASE + 32'h00, 32'h0, 32'h0102_0304, 1'b0);
      send(1'b0, W, 1'b0, BASE + 32'h3C, 32'h0, 32'h0F0F_0F0F, 1'b0);

      // half store into upper lanes, then sub-word reads of the result
      send(1'b1, W, 1'b0, BASE + 32'h14, 32'h1122_3344, 32'h0, 1'b0);
      send(1'b1, H, 1'b0, BASE + 32'h16, 32'h0000_A5C3, 32'h0, 1'b0);
      send(1'b0, W, 1'b0, BASE + 32'h14, 32'h0, 32'hA5C3_3344, 1'b0);
      send(1'b0, H, 1'b0, BASE + 32'h16, 32'h0, 32'hFFFF_A5C3, 1'b0);
      send(1'b0, B, 1'b0, BASE + 32'h15, 32'h0, 32'h0000_0033, 1'b0);
      send(1'b0, B, 1'b0, BASE + 32'h17, 32'h0, 32'hFFFF_FFA5, 1'b0);
      send(1'b0, H, 1'b1, BASE + 32'h14, 32'h0, 32'h0000_3344, 1'b0);

      // back-to-back: 7 stores then 8 consecutive loads of distinct words
      for (int i = 8; i < 15; i++) begin
         send(1'b1, W, 1'b0, BASE + 32'(4 * i), 32'h1111_1111 * 32'(i), 32'h0, 1'b0);
      end
      for (int i = 8; i < 16; i++) begin
         send(1'b0, W, 1'b0, BASE + 32'(4 * i), 32'h0,
              (i == 15) ? 32'h0F0F_0F0F : 32'h1111_1111 * 32'(i), 1'b0);
      end

      // reset with responses still in flight
      send(1'b0, W, 1'b0, BASE + 32'h10, 32'h0, 32'hDEAD_5AEF, 1'b0);
      send(1'b0, W, 1'b0, BASE + 32'h14, 32'h0, 32'hA5C3_3344, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_req_ready_1", 32'(rdy1), 32'h0);
      check("mid_rst_init_busy_2", 32'(busy2), 32'(INIT_EN));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      measure_init("init1");
      send(1'b0, W, 1'b0, BASE + 32'h10, 32'h0, INIT_EN ? 32'h0 : 32'hDEAD_5AEF, 1'b0);
      send(1'b0, W, 1'b0, BASE + 32'h3C, 32'h0, INIT_EN ? 32'h0 : 32'h0F0F_0F0F, 1'b0);

      // drain and confirm every expected response arrived
      for (int n = 0; n < 20 && (exp_q1.size() != 0 || exp_q2.size() != 0); n++) begin
         @(posedge clk);
      end
      repeat (3) @(posedge clk);
      #1;
      check("drain_q1", 32'(exp_q1.size()), 32'h0);
      check("drain_q2", 32'(exp_q2.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
